// File: rtl/sprite_scroll_engine.sv
// sprite_scroll_engine: background/sprite ROM address generator with scroll, animation and vblank-committed registers
// Ports:
//   clk, reset                                  clock; asynchronous active-high reset
//   writedata, write, chipselect, address       Avalon-MM write-only slave (regs 0..4)
//   hcount, vcount                              raster position from vga_counters (column = hcount[10:1])
//   bg_addr, spr_addr                           ROM addresses, one register stage after hcount/vcount
//   spr_frame, spr_hit                          frame index and sprite-box hit, aligned with ROM q
//   scroll_off                                  committed horizontal scroll offset
//   frame_tick                                  one-cycle pulse marking the start of vblank
module sprite_scroll_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BG_WIDTH    = 640,
  parameter int SPR_X       = 100,
  parameter int SPR_W       = 34,
  parameter int SPR_H       = 24,
  parameter int NUM_FRAMES  = 3,
  parameter int ROM_LATENCY = 1,
  parameter int BG_AW       = 19,
  parameter int SPR_AW      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        writedata,
  input  logic              write,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [BG_AW-1:0]  bg_addr,
  output logic [SPR_AW-1:0] spr_addr,
  output logic [1:0]        spr_frame,
  output logic              spr_hit,
  output logic [9:0]        scroll_off,
  output logic              frame_tick
);
  logic wr;
  logic [9:0] pend_y, com_y;
  logic [7:0] pend_step, com_step, pend_period, com_period, cnt;
  logic [2:0] pend_ctrl, com_ctrl;
  logic [1:0] frame;
  logic [9:0] adv, nxt_scroll, col, row;
  logic [10:0] sum, c, bc;
  logic active, in_box;
  logic [BG_AW-1:0] bg_n;
  logic [SPR_AW-1:0] spr_n;
  logic [ROM_LATENCY:0] hit_p;
  logic [ROM_LATENCY:0][1:0] frm_p;

  assign wr = chipselect && write;

  // A step at or beyond the background width advances nothing; with an
  // 8-bit step and a wide background that case cannot occur at all.
  generate
    if (BG_WIDTH > 255) begin : g_noclamp
      assign adv = {2'b0, com_step};
    end else begin : g_clamp
      assign adv = com_step >= 8'(BG_WIDTH) ? 10'd0 : {2'b0, com_step};
    end
  endgenerate

  always_comb begin
    sum = {1'b0, scroll_off} + {1'b0, adv};
    nxt_scroll = sum >= 11'(BG_WIDTH) ? 10'(sum - 11'(BG_WIDTH)) : sum[9:0];
    col = hcount[10:1];
    row = vcount;
    active = {1'b0, col} < 11'(H_ACTIVE) && {1'b0, row} < 11'(V_ACTIVE);
    c = {1'b0, col} + {1'b0, scroll_off};
    bc = c >= 11'(BG_WIDTH) ? c - 11'(BG_WIDTH) : c;
    // 11-bit row compare so a box near the bottom never wraps; clipping to
    // the visible area comes from gating with active.
    in_box = active && {1'b0, col} >= 11'(SPR_X) && {1'b0, col} < 11'(SPR_X + SPR_W)
             && {1'b0, row} >= {1'b0, com_y} && {1'b0, row} < {1'b0, com_y} + 11'(SPR_H);
    bg_n = active ? BG_AW'(row) * BG_AW'(BG_WIDTH) + BG_AW'(bc) : '0;
    spr_n = in_box ? SPR_AW'(row - com_y) * SPR_AW'(SPR_W) + SPR_AW'(col - 10'(SPR_X)) : '0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      frame_tick  <= 1'b0;
      pend_y      <= 10'(V_ACTIVE / 2);
      com_y       <= 10'(V_ACTIVE / 2);
      pend_step   <= 8'd1;
      com_step    <= 8'd1;
      pend_period <= 8'd6;
      com_period  <= 8'd6;
      pend_ctrl   <= 3'b011;
      com_ctrl    <= 3'b011;
      scroll_off  <= '0;
      frame       <= '0;
      cnt         <= '0;
    end else begin
      frame_tick <= hcount == 11'd0 && vcount == 10'(V_ACTIVE);
      // Scroll and animation use the values committed last frame; the
      // pending set is latched afterwards so the next frame sees it.
      if (frame_tick) begin
        com_y      <= pend_y;
        com_step   <= pend_step;
        com_period <= pend_period;
        com_ctrl   <= pend_ctrl;
        pend_ctrl[2] <= 1'b0;
        if (com_ctrl[0]) scroll_off <= nxt_scroll;
        if (com_ctrl[2]) begin
          frame <= '0;
          cnt   <= '0;
        end else if (com_ctrl[1] && com_period != 8'd0) begin
          cnt   <= cnt == com_period - 8'd1 ? 8'd0 : cnt + 8'd1;
          frame <= cnt != com_period - 8'd1 ? frame : frame == 2'(NUM_FRAMES - 1) ? 2'd0 : frame + 2'd1;
        end
      end
      // A write in the tick cycle lands only in the pending set; a ctrl
      // write overrides the restart self-clear above.
      if (wr && address == 3'd0) pend_y[7:0] <= writedata;
      if (wr && address == 3'd1) pend_y[9:8] <= writedata[1:0];
      if (wr && address == 3'd2) pend_step <= writedata;
      if (wr && address == 3'd3) pend_period <= writedata;
      if (wr && address == 3'd4) pend_ctrl <= writedata[2:0];
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bg_addr  <= '0;
      spr_addr <= '0;
      hit_p    <= '0;
      frm_p    <= '0;
    end else begin
      bg_addr  <= bg_n;
      spr_addr <= spr_n;
      hit_p    <= {hit_p[ROM_LATENCY-1:0], in_box};
      frm_p    <= {frm_p[ROM_LATENCY-1:0], frame};
    end

  assign spr_hit   = hit_p[ROM_LATENCY];
  assign spr_frame = frm_p[ROM_LATENCY];
endmodule

// File: tb/tb_sprite_scroll_engine.sv
// tb_sprite_scroll_engine: scoreboard bench driving raster positions and register writes
module tb_sprite_scroll_engine;
  localparam int L = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] writedata = '0;
  logic write = 1'b0, chipselect = 1'b0;
  logic [2:0] address = '0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [18:0] bg_addr;
  logic [11:0] spr_addr;
  logic [1:0] spr_frame;
  logic spr_hit;
  logic [9:0] scroll_off;
  logic frame_tick;

  sprite_scroll_engine #(.ROM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(chipselect),
    .address(address), .hcount(hcount), .vcount(vcount), .bg_addr(bg_addr), .spr_addr(spr_addr),
    .spr_frame(spr_frame), .spr_hit(spr_hit), .scroll_off(scroll_off), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct { int bg; int spr; } a_t;
  typedef struct { int hit; int frm; } h_t;
  a_t aq[$];
  h_t hq[$];
  int checks = 0, failures = 0;
  int m_y, m_step, m_per, m_ctrl, p_y, p_step, p_per, p_ctrl, m_off, m_frm, m_cnt;
  bit m_ft;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 240; p_y = 240; m_step = 1; p_step = 1; m_per = 6; p_per = 6;
    m_ctrl = 3; p_ctrl = 3; m_off = 0; m_frm = 0; m_cnt = 0; m_ft = 0;
    aq.delete();
    hq.delete();
    for (int i = 0; i < L; i++) hq.push_back('{0, 0});
  endtask

  task automatic cyc(input int h, input int v, input bit we = 0, input int a = 0, input int d = 0);
    int col, row, hit;
    a_t ea;
    h_t eh;
    @(negedge clk);
    hcount = 11'(h); vcount = 10'(v);
    write = we; chipselect = we; address = 3'(a); writedata = 8'(d);
    col = h / 2; row = v;
    hit = (col >= 100 && col < 134 && row >= m_y && row < m_y + 24 && row < 480) ? 1 : 0;
    ea.bg = (col < 640 && row < 480) ? row * 640 + (col + m_off) % 640 : 0;
    ea.spr = hit ? (row - m_y) * 34 + (col - 100) : 0;
    aq.push_back(ea);
    hq.push_back('{hit, m_frm});
    @(posedge clk);
    if (m_ft) begin
      if (m_ctrl & 1) m_off = m_step >= 640 ? m_off : (m_off + m_step) % 640;
      if (m_ctrl & 4) begin
        m_frm = 0; m_cnt = 0;
      end else if ((m_ctrl & 2) && m_per != 0) begin
        m_cnt = (m_cnt + 1) & 255;
        if (m_cnt == m_per) begin
          m_cnt = 0; m_frm = (m_frm + 1) % 3;
        end
      end
      m_y = p_y; m_step = p_step; m_per = p_per; m_ctrl = p_ctrl;
      p_ctrl = p_ctrl & 3;
    end
    if (we && a == 0) p_y = (p_y & 'h300) | d;
    if (we && a == 1) p_y = (p_y & 255) | ((d & 3) << 8);
    if (we && a == 2) p_step = d;
    if (we && a == 3) p_per = d;
    if (we && a == 4) p_ctrl = d & 7;
    m_ft = (h == 0 && v == 480);
    #1;
    check("frame_tick", 32'(frame_tick), m_ft);
    check("scroll_off", 32'(scroll_off), m_off);
    ea = aq.pop_front();
    check("bg_addr", 32'(bg_addr), ea.bg);
    check("spr_addr", 32'(spr_addr), ea.spr);
    if (hq.size() > L) begin
      eh = hq.pop_front();
      check("spr_hit", 32'(spr_hit), eh.hit);
      check("spr_frame", 32'(spr_frame), eh.frm);
    end
    write = 0; chipselect = 0;
  endtask

  task automatic probe_frame();
    int rows[7], cols[4];
    rows = '{m_y - 1, m_y, m_y + 23, m_y + 24, 479, 480, 0};
    cols = '{99, 100, 133, 134};
    foreach (rows[r]) foreach (cols[k]) cyc(cols[k] * 2 + int'($urandom_range(0, 1)), rows[r]);
    cyc(1000, 10);
    for (int i = 0; i < 4; i++) cyc(int'($urandom_range(1, 1599)), int'($urandom_range(0, 524)));
    cyc(0, 480);
  endtask

  task automatic reset_now();
    #2 reset = 1'b1;
    #1;
    check("rst_bg_addr", 32'(bg_addr), 0);
    check("rst_spr_addr", 32'(spr_addr), 0);
    check("rst_spr_hit", 32'(spr_hit), 0);
    check("rst_spr_frame", 32'(spr_frame), 0);
    check("rst_scroll_off", 32'(scroll_off), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    reset_now();
    probe_frame();
    cyc(10, 10, 1, 2, 200);
    repeat (5) probe_frame();
    cyc(10, 10, 1, 3, 2);
    repeat (7) probe_frame();
    cyc(10, 10, 1, 3, 0);
    repeat (3) probe_frame();
    cyc(300, 250, 1, 0, 100);
    cyc(300, 250, 1, 1, 0);
    cyc(220, 100);
    cyc(220, 110);
    probe_frame();
    probe_frame();
    cyc(0, 480, 1, 2, 7);
    repeat (2) probe_frame();
    cyc(2, 2, 1, 0, 214);
    cyc(2, 2, 1, 1, 1);
    cyc(2, 2, 1, 3, 1);
    repeat (2) probe_frame();
    cyc(2, 2, 1, 4, 6);
    cyc(2, 2, 1, 5, 0);
    repeat (3) probe_frame();
    cyc(2, 2, 1, 4, 3);
    repeat (3) probe_frame();
    cyc(400, 300);
    cyc(220, 470);
    reset_now();
    repeat (2) probe_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
